// File: rtl/equihash_pkg.sv
// Shared types for the equihash verifier and the arbiter that feeds it.
//   equihash_bm_t          : verifier result bitmask, one bit per failed check
//   equihash_req_id_t      : requester id wide enough for the largest arbiter
//   equihash_arb_state_t   : arbiter FSM states
//   EQUIHASH_ARB_MAX_REQ   : upper bound on arbiter requesters
//   AXI_CTL_BITS           : width of the AXI-stream ctl sideband
package equihash_pkg;

  localparam int EQUIHASH_ARB_MAX_REQ = 8;
  localparam int AXI_CTL_BITS         = 8;

  typedef logic [$clog2(EQUIHASH_ARB_MAX_REQ)-1:0] equihash_req_id_t;

  // All-zero means the header solution verified clean.
  typedef struct packed {
    logic rsvd;
    logic bad_target;
    logic bad_pow;
    logic bad_dup_idx;
    logic bad_order;
    logic bad_xor;
    logic bad_len;
    logic bad_sop;
  } equihash_bm_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } equihash_arb_state_t;

endpackage

// File: rtl/if_axi_stream.sv
// AXI-stream style packet interface.
//   val/rdy : beat handshake
//   sop/eop : first/last beat of a packet
//   ctl     : sideband control, mod: valid bytes in last beat, err: beat error
//   dat     : DAT_BYTS bytes of payload
interface if_axi_stream #(
  parameter int DAT_BYTS = 8,
  parameter int CTL_BITS = 8
);
  localparam int MOD_BITS = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  logic                  val;
  logic                  rdy;
  logic                  sop;
  logic                  eop;
  logic                  err;
  logic [CTL_BITS-1:0]   ctl;
  logic [MOD_BITS-1:0]   mod;
  logic [DAT_BYTS*8-1:0] dat;

  modport source (output val, sop, eop, err, ctl, mod, dat, input rdy);
  modport sink   (input  val, sop, eop, err, ctl, mod, dat, output rdy);
endinterface

// File: rtl/equihash_verif_arb_tag_fifo.sv
// In-order tag FIFO holding the requester id of every header in flight
// inside the verifier.
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_push, i_din  : enqueue an id
//   i_pop          : dequeue the head
//   o_full/o_empty : occupancy flags
//   o_head         : id at the head
//   o_count_nxt    : occupancy after this cycle's push/pop
// A pop on an empty FIFO with a same-cycle push is a bypass: the id passes
// straight through and nothing is stored. Push on full is accepted only
// alongside a pop.
module equihash_arb_tag_fifo
  import equihash_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  equihash_req_id_t        i_din,
  input  logic                    i_pop,
  output logic                    o_full,
  output logic                    o_empty,
  output equihash_req_id_t        o_head,
  output logic [$clog2(DEPTH):0]  o_count_nxt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  equihash_req_id_t   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               push_eff;
  logic               pop_eff;

  assign o_full   = (count == CNT_W'(DEPTH));
  assign o_empty  = (count == '0);
  assign o_head   = mem[rd_ptr];
  assign pop_eff  = i_pop & ~o_empty;
  assign push_eff = i_push & (~o_full | i_pop) & ~(i_pop & o_empty);

  always_comb begin
    o_count_nxt = count;
    case ({push_eff, pop_eff})
      2'b10:   o_count_nxt = count + CNT_W'(1);
      2'b01:   o_count_nxt = count - CNT_W'(1);
      default: o_count_nxt = count;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (push_eff) mem[wr_ptr] <= i_din;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_eff) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_eff)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= o_count_nxt;
    end
  end

endmodule

// File: rtl/equihash_verif_arb.sv
// Packet-atomic round-robin arbiter sharing one equihash verifier between
// N_REQ header sources, and routing each verifier result back to its owner.
//   i_clk, i_rst_n  : clock, synchronous active-low reset
//   i_axi[N_REQ]    : header streams from requesters
//   o_axi           : muxed header stream to the verifier
//   i_mask/_val     : verifier result and strobe
//   o_mask/_val/_id : result forwarded with the owning requester id
//   o_busy          : packet in transfer or results outstanding
//   o_err_spurious  : sticky, a result arrived with nothing in flight
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | no grant; all rdy low; pick next requester when FIFO has room
// ST_XFER | i_axi[grant] wired through to o_axi until its eop handshake
module equihash_verif_arb
  import equihash_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DAT_BYTS  = 8,
  parameter int MAX_OUTST = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  if_axi_stream.sink    i_axi [N_REQ],
  if_axi_stream.source  o_axi,
  input  equihash_bm_t  i_mask,
  input  logic          i_mask_val,
  output equihash_bm_t  o_mask,
  output logic          o_mask_val,
  output logic [$clog2(N_REQ)-1:0] o_mask_id,
  output logic          o_busy,
  output logic          o_err_spurious
);
  localparam int ID_W  = $clog2(N_REQ);
  localparam int MOD_W = (DAT_BYTS > 1) ? $clog2(DAT_BYTS) : 1;

  equihash_arb_state_t state_q, state_d;
  logic [ID_W-1:0]     grant_q, grant_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic                first_q, first_d;
  logic                push;

  logic [N_REQ-1:0]        req_val;
  logic [N_REQ-1:0]        req_sop;
  logic [N_REQ-1:0]        req_eop;
  logic [N_REQ-1:0]        req_err;
  logic [AXI_CTL_BITS-1:0] req_ctl [N_REQ];
  logic [MOD_W-1:0]        req_mod [N_REQ];
  logic [DAT_BYTS*8-1:0]   req_dat [N_REQ];

  logic                       fifo_full;
  logic                       fifo_empty;
  equihash_req_id_t           fifo_head;
  logic [$clog2(MAX_OUTST):0] fifo_cnt_nxt;
  logic                       pop;
  logic                       spurious;
  logic [ID_W-1:0]            mask_id_d;

  // First requester with val at or after ptr, wrapping.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] val,
                                              input logic [ID_W-1:0]  ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && val[idx]) begin
        found = 1'b1;
        pick  = ID_W'(idx);
      end
    end
    return pick;
  endfunction

  for (genvar k = 0; k < N_REQ; k++) begin : g_req
    assign req_val[k] = i_axi[k].val;
    assign req_sop[k] = i_axi[k].sop;
    assign req_eop[k] = i_axi[k].eop;
    assign req_err[k] = i_axi[k].err;
    assign req_ctl[k] = i_axi[k].ctl;
    assign req_mod[k] = i_axi[k].mod;
    assign req_dat[k] = i_axi[k].dat;
    assign i_axi[k].rdy = (state_q == ST_XFER) && (grant_q == ID_W'(k)) && o_axi.rdy;
  end

  // sop is not checked here; a malformed packet is forwarded as-is.
  assign o_axi.val = (state_q == ST_XFER) && req_val[grant_q];
  assign o_axi.sop = req_sop[grant_q];
  assign o_axi.eop = req_eop[grant_q];
  assign o_axi.err = req_err[grant_q];
  assign o_axi.ctl = req_ctl[grant_q];
  assign o_axi.mod = req_mod[grant_q];
  assign o_axi.dat = req_dat[grant_q];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    first_d = first_q;
    push    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|req_val) && !fifo_full) begin
          grant_d = rr_pick(req_val, rr_q);
          first_d = 1'b1;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        if (req_val[grant_q] && o_axi.rdy) begin
          push    = first_q;
          first_d = 1'b0;
          if (req_eop[grant_q]) begin
            rr_d    = (grant_q == ID_W'(N_REQ-1)) ? '0 : grant_q + ID_W'(1);
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      first_q <= first_d;
    end
  end

  // Empty FIFO with a same-cycle push: the result belongs to the packet
  // being pushed right now, so its id is the current grant.
  assign pop       = i_mask_val & (~fifo_empty | push);
  assign spurious  = i_mask_val & fifo_empty & ~push;
  assign mask_id_d = fifo_empty ? grant_q : ID_W'(fifo_head);

  equihash_arb_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (push),
    .i_din       (equihash_req_id_t'(grant_q)),
    .i_pop       (pop),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_head      (fifo_head),
    .o_count_nxt (fifo_cnt_nxt)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_mask         <= '0;
      o_mask_val     <= 1'b0;
      o_mask_id      <= '0;
      o_busy         <= 1'b0;
      o_err_spurious <= 1'b0;
    end else begin
      o_mask_val <= i_mask_val;
      if (i_mask_val) begin
        o_mask    <= i_mask;
        o_mask_id <= spurious ? '0 : mask_id_d;
      end
      if (spurious) o_err_spurious <= 1'b1;
      o_busy <= (state_d == ST_XFER) || (fifo_cnt_nxt != '0);
    end
  end

endmodule

// File: tb/tb_equihash_verif_arb.sv
// Directed bench for equihash_verif_arb: grant order, idle gap, FIFO stall,
// push/pop coincidence, spurious results and mid-packet reset.
module tb_equihash_verif_arb;
  import equihash_pkg::*;

  localparam int N   = 4;
  localparam int DB  = 8;
  localparam int LEN = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sink_rdy;
  equihash_bm_t mask;
  logic         mask_val;
  equihash_bm_t dut_mask;
  logic         dut_mval;
  logic [1:0]   dut_mid;
  logic         dut_busy;
  logic         dut_err;

  int n_tests = 0;
  int n_fail  = 0;
  int issue [N];

  int cyc        = 0;
  int eop_cnt    = 0;
  int beats_seen = 0;
  int sop_owner [$];
  int sop_cyc   [$];
  int eop_cyc   [$];
  int mask_cyc  [$];

  logic [N-1:0] req_rdy_v;

  always #5 clk = ~clk;

  if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(AXI_CTL_BITS)) req_if [N] ();
  if_axi_stream #(.DAT_BYTS(DB), .CTL_BITS(AXI_CTL_BITS)) out_if ();

  assign out_if.rdy = sink_rdy;

  for (genvar k = 0; k < N; k++) begin : g_req
    int done_q = 0;
    int beat_q = 0;
    assign req_if[k].val = (done_q < issue[k]);
    assign req_if[k].sop = (beat_q == 0);
    assign req_if[k].eop = (beat_q == LEN-1);
    assign req_if[k].err = 1'b0;
    assign req_if[k].ctl = 8'(k);
    assign req_if[k].mod = '0;
    assign req_if[k].dat = {8'(k), 8'(done_q), 8'(beat_q), 40'h0};
    assign req_rdy_v[k]  = req_if[k].rdy;
    always @(posedge clk) begin
      if (!rst_n) beat_q <= 0;
      else if (req_if[k].val && req_if[k].rdy) begin
        if (beat_q == LEN-1) begin
          beat_q <= 0;
          done_q <= done_q + 1;
        end else begin
          beat_q <= beat_q + 1;
        end
      end
    end
  end

  equihash_verif_arb #(.N_REQ(N), .DAT_BYTS(DB), .MAX_OUTST(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_axi          (req_if),
    .o_axi          (out_if),
    .i_mask         (mask),
    .i_mask_val     (mask_val),
    .o_mask         (dut_mask),
    .o_mask_val     (dut_mval),
    .o_mask_id      (dut_mid),
    .o_busy         (dut_busy),
    .o_err_spurious (dut_err)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (out_if.val && out_if.rdy) begin
        beats_seen <= beats_seen + 1;
        if (out_if.sop) begin
          sop_owner.push_back(int'(out_if.dat[63:56]));
          sop_cyc.push_back(cyc);
        end
        if (out_if.eop) begin
          eop_cnt <= eop_cnt + 1;
          eop_cyc.push_back(cyc);
        end
      end
      if (mask_val) mask_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_eops(input int target, input int budget, input string tag);
    int n = 0;
    while (eop_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(eop_cnt >= target), 32'd1);
  endtask

  task automatic wait_sops(input int target, input int budget, input string tag);
    int n = 0;
    while (sop_owner.size() < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(sop_owner.size() >= target), 32'd1);
  endtask

  // Drive a one-cycle result strobe; returns with the registered output visible.
  task automatic pulse_mask(input logic [7:0] v);
    mask     = equihash_bm_t'(v);
    mask_val = 1'b1;
    tick();
    mask_val = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bs, be, bb, n, nval;
    rst_n    = 1'b0;
    sink_rdy = 1'b1;
    mask     = '0;
    mask_val = 1'b0;
    for (int k = 0; k < N; k++) issue[k] = 0;
    repeat (2) tick();

    // Reset state, including while a requester already holds val.
    issue[0] = 1;
    tick();
    check_eq("rst_mval",  32'(dut_mval), 0);
    check_eq("rst_mask",  32'(dut_mask), 0);
    check_eq("rst_mid",   32'(dut_mid), 0);
    check_eq("rst_busy",  32'(dut_busy), 0);
    check_eq("rst_err",   32'(dut_err), 0);
    check_eq("rst_oval",  32'(out_if.val), 0);
    check_eq("rst_rdy",   32'(req_rdy_v), 0);

    // Single clean header from requester 0, verifier returns mask 0.
    bs = sop_owner.size(); be = eop_cnt; bb = beats_seen;
    rst_n = 1'b1;
    wait_eops(be + 1, 50, "t2_done");
    check_eq("t2_owner", 32'(sop_owner[bs]), 0);
    check_eq("t2_beats", 32'(beats_seen - bb), LEN);
    check_eq("t2_busy_inflight", 32'(dut_busy), 1);
    pulse_mask(8'h00);
    check_eq("t2_mval", 32'(dut_mval), 1);
    check_eq("t2_mid",  32'(dut_mid), 0);
    check_eq("t2_mask", 32'(dut_mask), 0);
    check_eq("t2_err",  32'(dut_err), 0);
    check_eq("t2_busy_done", 32'(dut_busy), 0);
    tick();
    check_eq("t2_mval_single", 32'(dut_mval), 0);

    // Requesters 0 and 2 from reset release; one idle cycle between packets.
    rst_n = 1'b0;
    issue[0]++; issue[2]++;
    bs = sop_owner.size(); be = eop_cnt;
    tick();
    rst_n = 1'b1;
    wait_eops(be + 2, 80, "t3_done");
    check_eq("t3_owner0", 32'(sop_owner[bs]), 0);
    check_eq("t3_owner1", 32'(sop_owner[bs+1]), 2);
    check_eq("t3_gap", 32'(sop_cyc[bs+1] - eop_cyc[be]), 2);
    pulse_mask(8'h3C);
    check_eq("t3_mid0",  32'(dut_mid), 0);
    check_eq("t3_mask0", 32'(dut_mask), 32'h3C);
    tick();
    pulse_mask(8'hC3);
    check_eq("t3_mid1",  32'(dut_mid), 2);
    check_eq("t3_mask1", 32'(dut_mask), 32'hC3);
    check_eq("t3_busy",  32'(dut_busy), 0);

    // Five packets queued, depth 4: stall after four.
    rst_n = 1'b0;
    issue[0] += 2; issue[1]++; issue[2]++; issue[3]++;
    bs = sop_owner.size(); be = eop_cnt;
    tick();
    rst_n = 1'b1;
    wait_eops(be + 4, 120, "t4_four_done");
    nval = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_if.val) nval++;
    end
    check_eq("t4_stall_val",  32'(nval), 0);
    check_eq("t4_stall_eops", 32'(eop_cnt - be), 4);
    check_eq("t4_stall_busy", 32'(dut_busy), 1);
    for (int i = 0; i < 4; i++) check_eq("t4_owner", 32'(sop_owner[bs+i]), 32'(i));
    pulse_mask(8'h11);
    check_eq("t4_pop_mid", 32'(dut_mid), 0);
    tick();
    // Second result lands on the same edge as the fifth packet's sop push.
    pulse_mask(8'h22);
    check_eq("t4_coin_mid",  32'(dut_mid), 1);
    check_eq("t4_coin_mask", 32'(dut_mask), 32'h22);
    wait_sops(bs + 5, 5, "t4_fifth_seen");
    check_eq("t4_fifth_owner", 32'(sop_owner[bs+4]), 0);
    n = mask_cyc.size();
    check_eq("t4_fifth_gap", 32'(sop_cyc[bs+4] - mask_cyc[n-2]), 2);
    check_eq("t4_coincide",  32'(sop_cyc[bs+4] - mask_cyc[n-1]), 0);
    wait_eops(be + 5, 50, "t4_fifth_done");
    pulse_mask(8'h33);
    check_eq("t4_mid_a", 32'(dut_mid), 2);
    tick();
    pulse_mask(8'h44);
    check_eq("t4_mid_b", 32'(dut_mid), 3);
    tick();
    pulse_mask(8'h55);
    check_eq("t4_mid_c",   32'(dut_mid), 0);
    check_eq("t4_mask_c",  32'(dut_mask), 32'h55);
    check_eq("t4_err_pre", 32'(dut_err), 0);
    check_eq("t4_busy_empty", 32'(dut_busy), 0);
    tick();
    // Nothing left in flight: spurious result.
    pulse_mask(8'h66);
    check_eq("sp_mval", 32'(dut_mval), 1);
    check_eq("sp_mid",  32'(dut_mid), 0);
    check_eq("sp_err",  32'(dut_err), 1);
    check_eq("sp_busy", 32'(dut_busy), 0);
    repeat (3) tick();
    check_eq("sp_err_sticky", 32'(dut_err), 1);
    check_eq("sp_mval_low",   32'(dut_mval), 0);

    // Reset in the middle of a packet from requester 1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("t5_err_cleared", 32'(dut_err), 0);
    be = eop_cnt;
    issue[0]++;
    wait_eops(be + 1, 50, "t5_pre_done");
    issue[1]++;
    n = 0;
    while (g_req[1].beat_q != 3 && n < 50) begin
      tick();
      n++;
    end
    check_eq("t5_reached_beat3", 32'(g_req[1].beat_q), 3);
    check_eq("t5_busy_before", 32'(dut_busy), 1);
    issue[0]++;
    rst_n = 1'b0;
    tick();
    check_eq("t5_rdy",  32'(req_rdy_v), 0);
    check_eq("t5_oval", 32'(out_if.val), 0);
    check_eq("t5_busy", 32'(dut_busy), 0);
    bs = sop_owner.size();
    rst_n = 1'b1;
    wait_sops(bs + 1, 20, "t5_regrant");
    check_eq("t5_owner_after_rst", 32'(sop_owner[bs]), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
